// File: rtl/itrx_aib_phy_dll_cal.sv
// rtl/itrx_aib_phy_dll_cal.sv - AIB manual-mode DLL calibration sequencer
//
// Sweeps the DLL adjust code upward from 0, lets each code settle, takes a
// majority vote of the synchronized phase detector and locks on the first
// code whose vote is 1 after at least one earlier vote of 0.
//
// Ports:
//   clk, rst_n        controller clock, synchronous active-low reset
//   cal_start         one-cycle pulse, starts/restarts calibration (IDLE/LOCKED/FAIL)
//   manual_en         software override, aborts calibration
//   manual_code       adjust code driven while manual_en=1
//   pd_in             asynchronous phase detector input
//   dll_enable        DLL enable
//   dll_lock_req      DLL lock request, equals cal_busy
//   dll_adjust        DLL delay select (the code register)
//   cal_busy          sweep in progress
//   cal_done          one-cycle pulse on entry to LOCKED
//   cal_fail          no 0-to-1 transition found
//   lock              code valid and held
module itrx_aib_phy_dll_cal #(
    parameter int DLYW     = 10,
    parameter int MAX_CODE = 63,
    parameter int SETTLE   = 8,
    parameter int NSAMP    = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            cal_start,
    input  logic            manual_en,
    input  logic [DLYW-1:0] manual_code,
    input  logic            pd_in,
    output logic            dll_enable,
    output logic            dll_lock_req,
    output logic [DLYW-1:0] dll_adjust,
    output logic            cal_busy,
    output logic            cal_done,
    output logic            cal_fail,
    output logic            lock
);

    localparam int CMAX = (SETTLE > NSAMP) ? SETTLE : NSAMP;
    localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;
    localparam int OW   = $clog2(NSAMP + 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_SAMPLE,
        ST_EVAL,
        ST_LOCKED,
        ST_FAIL
    } state_t;

    state_t          state, state_n;
    logic [DLYW-1:0] code, code_n;
    logic [CW-1:0]   cnt, cnt_n;
    logic [OW-1:0]   ones, ones_n;
    logic            seen_low, seen_low_n;
    logic            lock_n, cal_done_n, cal_fail_n;
    logic            busy_n, enable_n;
    logic            pd_meta, pd_s;
    logic            vote;

    // Majority vote; an exact tie counts as 0.
    assign vote = (ones > OW'(NSAMP / 2));

    always_comb begin
        state_n    = state;
        code_n     = code;
        cnt_n      = cnt;
        ones_n     = ones;
        seen_low_n = seen_low;
        lock_n     = lock;
        cal_done_n = 1'b0;
        cal_fail_n = cal_fail;

        if (manual_en) begin
            state_n    = ST_IDLE;
            code_n     = manual_code;
            lock_n     = 1'b0;
            cal_fail_n = 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cal_start) begin
                        state_n    = ST_SETTLE;
                        code_n     = '0;
                        cnt_n      = '0;
                        seen_low_n = 1'b0;
                        cal_fail_n = 1'b0;
                    end
                end
                ST_SETTLE: begin
                    if (cnt == CW'(SETTLE - 1)) begin
                        state_n = ST_SAMPLE;
                        cnt_n   = '0;
                        ones_n  = '0;
                    end else begin
                        cnt_n = cnt + 1'b1;
                    end
                end
                ST_SAMPLE: begin
                    ones_n = ones + OW'(pd_s);
                    if (cnt == CW'(NSAMP - 1)) begin
                        state_n = ST_EVAL;
                        cnt_n   = '0;
                    end else begin
                        cnt_n = cnt + 1'b1;
                    end
                end
                ST_EVAL: begin
                    if (!vote) begin
                        seen_low_n = 1'b1;
                    end
                    if (vote && seen_low) begin
                        state_n    = ST_LOCKED;
                        lock_n     = 1'b1;
                        cal_done_n = 1'b1;
                    end else if (code == DLYW'(MAX_CODE)) begin
                        // Failure parks the delay line at code 0.
                        state_n    = ST_FAIL;
                        code_n     = '0;
                        cal_fail_n = 1'b1;
                    end else begin
                        state_n = ST_SETTLE;
                        code_n  = code + 1'b1;
                        cnt_n   = '0;
                    end
                end
                ST_LOCKED, ST_FAIL: begin
                    if (cal_start) begin
                        state_n    = ST_SETTLE;
                        code_n     = '0;
                        cnt_n      = '0;
                        seen_low_n = 1'b0;
                        lock_n     = 1'b0;
                        cal_fail_n = 1'b0;
                    end
                end
                default: begin
                    state_n = ST_IDLE;
                end
            endcase
        end

        busy_n   = (state_n == ST_SETTLE) || (state_n == ST_SAMPLE) || (state_n == ST_EVAL);
        enable_n = (state_n != ST_IDLE) || manual_en;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            code         <= '0;
            cnt          <= '0;
            ones         <= '0;
            seen_low     <= 1'b0;
            lock         <= 1'b0;
            cal_done     <= 1'b0;
            cal_fail     <= 1'b0;
            cal_busy     <= 1'b0;
            dll_lock_req <= 1'b0;
            dll_enable   <= 1'b0;
            pd_meta      <= 1'b0;
            pd_s         <= 1'b0;
        end else begin
            state        <= state_n;
            code         <= code_n;
            cnt          <= cnt_n;
            ones         <= ones_n;
            seen_low     <= seen_low_n;
            lock         <= lock_n;
            cal_done     <= cal_done_n;
            cal_fail     <= cal_fail_n;
            cal_busy     <= busy_n;
            dll_lock_req <= busy_n;
            dll_enable   <= enable_n;
            pd_meta      <= pd_in;
            pd_s         <= pd_meta;
        end
    end

    assign dll_adjust = code;

endmodule

// File: tb/tb_itrx_aib_phy_dll_cal.sv
// tb/tb_itrx_aib_phy_dll_cal.sv - directed self-checking bench for itrx_aib_phy_dll_cal
module tb_itrx_aib_phy_dll_cal;

    localparam int DLYW = 10;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            cal_start;
    logic            manual_en;
    logic [DLYW-1:0] manual_code;
    logic            pd_in;
    logic            dll_enable;
    logic            dll_lock_req;
    logic [DLYW-1:0] dll_adjust;
    logic            cal_busy;
    logic            cal_done;
    logic            cal_fail;
    logic            lock;

    int checks = 0;
    int passes = 0;
    int fails  = 0;

    // Phase detector model: 0 const0, 1 const1, 2 threshold, 3 noisy 17..19.
    int          pd_mode = 1;
    int          thr     = 17;
    logic        tog     = 1'b0;
    int          n;

    always #5 clk = ~clk;
    always @(posedge clk) tog <= ~tog;

    always_comb begin
        case (pd_mode)
            0:       pd_in = 1'b0;
            1:       pd_in = 1'b1;
            2:       pd_in = (int'(dll_adjust) >= thr);
            default: pd_in = (dll_adjust >= 10'd20) || ((dll_adjust >= 10'd17) && tog);
        endcase
    end

    itrx_aib_phy_dll_cal dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cal_start    (cal_start),
        .manual_en    (manual_en),
        .manual_code  (manual_code),
        .pd_in        (pd_in),
        .dll_enable   (dll_enable),
        .dll_lock_req (dll_lock_req),
        .dll_adjust   (dll_adjust),
        .cal_busy     (cal_busy),
        .cal_done     (cal_done),
        .cal_fail     (cal_fail),
        .lock         (lock)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Pulse cal_start for one edge; returns at the falling edge after that edge.
    task automatic start_cal();
        @(negedge clk);
        cal_start = 1'b1;
        @(negedge clk);
        cal_start = 1'b0;
    endtask

    // Counts cycles after the start edge until cal_done (which=0) or cal_fail (which=1).
    task automatic wait_evt(input int which, input int limit, output int cycles);
        cycles = 0;
        while (cycles < limit) begin
            @(negedge clk);
            cycles++;
            if ((which == 0 && cal_done) || (which == 1 && cal_fail)) break;
        end
    endtask

    initial begin
        rst_n       = 1'b0;
        cal_start   = 1'b1;
        manual_en   = 1'b0;
        manual_code = '0;
        pd_mode     = 1;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_lock", lock, 0);
        chk("rst_done", cal_done, 0);
        chk("rst_fail", cal_fail, 0);
        chk("rst_busy", cal_busy, 0);
        chk("rst_enable", dll_enable, 0);
        chk("rst_lockreq", dll_lock_req, 0);
        chk("rst_adjust", dll_adjust, 0);

        rst_n     = 1'b1;
        cal_start = 1'b0;
        repeat (5) @(negedge clk);
        chk("idle_enable", dll_enable, 0);
        chk("idle_busy", cal_busy, 0);

        // Normal lock at threshold 17: 18 codes * 13 cycles.
        pd_mode = 2;
        thr     = 17;
        start_cal();
        chk("start_busy", cal_busy, 1);
        chk("start_lockreq", dll_lock_req, 1);
        chk("start_enable", dll_enable, 1);
        wait_evt(0, 1000, n);
        chk("lock17_cycles", n, 234);
        chk("lock17_lock", lock, 1);
        chk("lock17_adjust", dll_adjust, 17);
        @(negedge clk);
        chk("lock17_done_pulse", cal_done, 0);
        chk("lock17_busy", cal_busy, 0);
        chk("lock17_hold", lock, 1);

        // Relock at threshold 40: 41 codes * 13 cycles.
        thr = 40;
        start_cal();
        chk("relock_lockdrop", lock, 0);
        chk("relock_busy", cal_busy, 1);
        chk("relock_adjust0", dll_adjust, 0);
        wait_evt(0, 1000, n);
        chk("lock40_cycles", n, 533);
        chk("lock40_adjust", dll_adjust, 40);
        chk("lock40_lock", lock, 1);

        // No transition, pd always 0: 64 codes * 13 cycles.
        pd_mode = 0;
        start_cal();
        wait_evt(1, 2000, n);
        chk("fail0_cycles", n, 832);
        chk("fail0_lock", lock, 0);
        chk("fail0_adjust", dll_adjust, 0);
        chk("fail0_busy", cal_busy, 0);

        // pd always 1: never sees a low vote, also fails.
        pd_mode = 1;
        start_cal();
        chk("retry_fail_clear", cal_fail, 0);
        wait_evt(1, 2000, n);
        chk("fail1_cycles", n, 832);
        chk("fail1_lock", lock, 0);
        chk("fail1_adjust", dll_adjust, 0);

        // Ties at codes 17..19 vote 0; clean 1 from code 20.
        pd_mode = 3;
        start_cal();
        chk("noisy_fail_clear", cal_fail, 0);
        wait_evt(0, 1000, n);
        chk("noisy_cycles", n, 273);
        chk("noisy_adjust", dll_adjust, 20);

        // Manual abort in SAMPLE of code 9 (after start edge + 126 edges).
        pd_mode = 2;
        thr     = 40;
        start_cal();
        repeat (126) @(negedge clk);
        chk("pre_abort_adjust", dll_adjust, 9);
        chk("pre_abort_busy", cal_busy, 1);
        manual_en   = 1'b1;
        manual_code = 10'd300;
        @(negedge clk);
        chk("abort_busy", cal_busy, 0);
        chk("abort_adjust", dll_adjust, 300);
        chk("abort_enable", dll_enable, 1);
        chk("abort_lock", lock, 0);
        chk("abort_done", cal_done, 0);
        chk("abort_lockreq", dll_lock_req, 0);

        // cal_start is ignored while manual_en is high.
        start_cal();
        chk("manual_start_busy", cal_busy, 0);
        manual_en = 1'b0;
        repeat (3) @(negedge clk);
        chk("release_adjust", dll_adjust, 300);
        chk("release_enable", dll_enable, 0);
        chk("release_busy", cal_busy, 0);
        chk("release_done", cal_done, 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
